// File: rtl/aes_round_sequencer_if.sv
// Handshake bundle between the AES round sequencer, the key-expansion unit and the round datapath.
// The abort input exists only when AES_SEQ_ABORT_EN is defined.
interface aes_round_sequencer_if #(
    parameter int RIDX_W = 4
);
    logic              start;
    logic [1:0]        key_len;
    logic              key_req;
    logic [RIDX_W-1:0] key_idx;
    logic              key_vld;
    logic              round_en;
    logic [1:0]        round_type;
    logic [RIDX_W-1:0] round_idx;
    logic              busy;
    logic              done;
    logic              done_ack;
    logic              err;
`ifdef AES_SEQ_ABORT_EN
    logic              abort;

    modport slave (
        input  start, key_len, key_vld, done_ack, abort,
        output key_req, key_idx, round_en, round_type, round_idx, busy, done, err
    );
    modport master (
        output start, key_len, key_vld, done_ack, abort,
        input  key_req, key_idx, round_en, round_type, round_idx, busy, done, err
    );
`else
    modport slave (
        input  start, key_len, key_vld, done_ack,
        output key_req, key_idx, round_en, round_type, round_idx, busy, done, err
    );
    modport master (
        output start, key_len, key_vld, done_ack,
        input  key_req, key_idx, round_en, round_type, round_idx, busy, done, err
    );
`endif
endinterface

// File: rtl/aes_round_sequencer.sv
// AES encrypt round controller: fetches each round key, then strobes the round datapath.
// Optional macro AES_SEQ_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module aes_round_sequencer #(
    parameter int RIDX_W      = 4,
    parameter int KEY_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_round_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_KREQ = 2'b01,
        ST_EXEC = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam int               CNT_W   = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((KEY_TIMEOUT > 0) ? KEY_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reserved key length code falls back to AES-128.
    function automatic logic [RIDX_W-1:0] nr_of(input logic [1:0] len);
        logic [RIDX_W-1:0] nr;
        case (len)
            2'b01:   nr = RIDX_W'(12);
            2'b10:   nr = RIDX_W'(14);
            default: nr = RIDX_W'(10);
        endcase
        return nr;
    endfunction

    state_t            state_r, next_s;
    logic [RIDX_W-1:0] nr_r, round_idx_r, round_idx_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [1:0]        round_type_r, round_type_s;
    logic              key_req_r, round_en_r, busy_r, done_r, err_r;
    logic              accept_s, timeout_s, abort_hit_s, timeout_hit_s;

    // The counter value is the number of unanswered cycles already spent in KREQ.
    assign timeout_hit_s = (KEY_TIMEOUT != 0) && (cnt_r >= TO_LAST);

    // Next-state decode; abort (when built in) outranks key_vld and done_ack.
    always_comb begin
        next_s      = state_r;
        accept_s    = 1'b0;
        timeout_s   = 1'b0;
        abort_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    next_s   = ST_KREQ;
                    accept_s = 1'b1;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_KREQ: begin
`ifdef AES_SEQ_ABORT_EN
                if (bus.abort) begin
                    next_s      = ST_IDLE;
                    abort_hit_s = 1'b1;
                end else
`endif
                if (bus.key_vld) begin
                    next_s = ST_EXEC;
                end else if (timeout_hit_s) begin
                    next_s    = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    next_s = ST_KREQ;
                end
            end
            ST_EXEC: begin
`ifdef AES_SEQ_ABORT_EN
                if (bus.abort) begin
                    next_s      = ST_IDLE;
                    abort_hit_s = 1'b1;
                end else
`endif
                if (round_idx_r == nr_r) begin
                    next_s = ST_DONE;
                end else begin
                    next_s = ST_KREQ;
                end
            end
            ST_DONE: begin
`ifdef AES_SEQ_ABORT_EN
                if (bus.abort) begin
                    next_s      = ST_IDLE;
                    abort_hit_s = 1'b1;
                end else
`endif
                if (bus.done_ack) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            default: next_s = ST_IDLE;
        endcase
    end

    // Round index, timeout counter and round flavour for the next cycle.
    always_comb begin
        round_idx_s  = round_idx_r;
        cnt_s        = {CNT_W{1'b0}};
        round_type_s = 2'b00;
        if (accept_s || abort_hit_s) begin
            round_idx_s = {RIDX_W{1'b0}};
        end else if ((state_r == ST_EXEC) && (next_s == ST_KREQ)) begin
            round_idx_s = round_idx_r + RIDX_W'(1);
        end else begin
            round_idx_s = round_idx_r;
        end
        if ((state_r == ST_KREQ) && (next_s == ST_KREQ)) begin
            if (cnt_r != CNT_MAX) begin
                cnt_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = {CNT_W{1'b0}};
        end
        if (next_s == ST_EXEC) begin
            if (round_idx_r == {RIDX_W{1'b0}}) begin
                round_type_s = 2'b00;
            end else if (round_idx_r == nr_r) begin
                round_type_s = 2'b10;
            end else begin
                round_type_s = 2'b01;
            end
        end else begin
            round_type_s = 2'b00;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nr_r         <= RIDX_W'(10);
            round_idx_r  <= {RIDX_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            round_type_r <= 2'b00;
            key_req_r    <= 1'b0;
            round_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            round_idx_r  <= round_idx_s;
            cnt_r        <= cnt_s;
            round_type_r <= round_type_s;
            key_req_r    <= (next_s == ST_KREQ);
            round_en_r   <= (next_s == ST_EXEC);
            busy_r       <= (next_s != ST_IDLE);
            done_r       <= (next_s == ST_DONE);
            if (accept_s) begin
                nr_r  <= nr_of(bus.key_len);
                err_r <= 1'b0;
            end else if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign bus.key_req    = key_req_r;
    assign bus.key_idx    = round_idx_r;
    assign bus.round_en   = round_en_r;
    assign bus.round_type = round_type_r;
    assign bus.round_idx  = round_idx_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed self-checking bench for aes_round_sequencer; abort scenario runs when AES_SEQ_ABORT_EN is defined.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    aes_round_sequencer_if #(.RIDX_W(4)) bus ();

    aes_round_sequencer #(.RIDX_W(4), .KEY_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from IDLE and measures it; cycle 0 is the cycle start is presented.
    task automatic run_block(input logic [1:0] len, input int exp_nr, input int stall_round,
                             input int stall_cyc, input int poke_round, input logic ack_with_start,
                             output int pulses, output int done_cyc, output int bad_seq,
                             output int last_idx, output int req_run, output logic done_held,
                             output logic busy_after, output logic err_seen);
        int         c;
        int         wait_cnt;
        int         exp_c;
        logic [1:0] et;
        pulses = 0; done_cyc = -1; bad_seq = 0; last_idx = -1; req_run = 0;
        wait_cnt = 0; err_seen = 1'b0; done_held = 1'b1; c = 0;
        bus.key_len = len; bus.key_vld = 1'b1; bus.start = 1'b1;
        while (done_cyc < 0 && c < 60) begin
            tick(); c++;
            bus.start = 1'b0;
            bus.key_len = len ^ 2'b01;
            if (bus.err) err_seen = 1'b1;
            if (bus.round_en) begin
                exp_c = 2 * (pulses + 1) + ((pulses >= stall_round) ? stall_cyc : 0);
                if (pulses == 0) et = 2'b00;
                else if (pulses == exp_nr) et = 2'b10;
                else et = 2'b01;
                if (c != exp_c || bus.round_type !== et || bus.round_idx !== pulses[3:0]) bad_seq++;
                if (bus.key_req) bad_seq++;
                if (bus.round_idx == poke_round) bus.start = 1'b1;
                pulses++;
            end
            if (bus.key_req && bus.key_idx !== bus.round_idx) bad_seq++;
            if (bus.key_req && bus.key_idx == stall_round) req_run++;
            if (bus.done) begin
                done_cyc = c;
                last_idx = int'(bus.round_idx);
            end
            if (bus.key_req && bus.key_idx == stall_round && wait_cnt < stall_cyc) begin
                bus.key_vld = 1'b0;
                wait_cnt++;
            end else begin
                bus.key_vld = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (!(bus.done && bus.busy && int'(bus.round_idx) == last_idx)) done_held = 1'b0;
        end
        bus.done_ack = 1'b1; bus.start = ack_with_start;
        tick();
        bus.done_ack = 1'b0; bus.start = 1'b0;
        busy_after = bus.busy | bus.done;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({bus.key_req, bus.key_idx, bus.round_en, bus.round_type, bus.round_idx,
             bus.busy, bus.done, bus.err} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want all zero", {bus.key_req, bus.key_idx,
                     bus.round_en, bus.round_type, bus.round_idx, bus.busy, bus.done, bus.err});
        end
        tick(); rst = 1'b1; tick(); tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_hold: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_aes128();
        int p, dc, bs, li, rr; logic dh, ba, es;
        run_block(2'b00, 10, 99, 0, 99, 1'b0, p, dc, bs, li, rr, dh, ba, es);
        vectors++; if (p !== 11) begin miscompares++; $display("FAIL aes128_pulses: got %0d want 11", p); end
        vectors++; if (dc !== 23) begin miscompares++; $display("FAIL aes128_done_cycle: got %0d want 23", dc); end
        vectors++; if (bs !== 0) begin miscompares++; $display("FAIL aes128_sequence: got %0d bad want 0", bs); end
        vectors++; if (li !== 10) begin miscompares++; $display("FAIL aes128_final_idx: got %0d want 10", li); end
        vectors++; if (dh !== 1'b1) begin miscompares++; $display("FAIL aes128_done_held: got %b want 1", dh); end
        vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL aes128_idle_after_ack: got %b want 0", ba); end
    endtask

    task automatic test_key_lengths();
        int p, dc, bs, li, rr; logic dh, ba, es;
        logic [1:0] lens [3];
        int         nrs  [3];
        lens[0] = 2'b10; nrs[0] = 14;
        lens[1] = 2'b11; nrs[1] = 10;
        lens[2] = 2'b01; nrs[2] = 12;
        for (int k = 0; k < 3; k++) begin
            run_block(lens[k], nrs[k], 99, 0, 99, 1'b0, p, dc, bs, li, rr, dh, ba, es);
            vectors++;
            if (p !== nrs[k] + 1 || li !== nrs[k]) begin
                miscompares++;
                $display("FAIL keylen_%b_count: pulses %0d idx %0d want %0d %0d", lens[k], p, li, nrs[k] + 1, nrs[k]);
            end
            vectors++;
            if (bs !== 0 || dc !== 2 * (nrs[k] + 1) + 1) begin
                miscompares++;
                $display("FAIL keylen_%b_timing: bad %0d done %0d want 0 %0d", lens[k], bs, dc, 2 * (nrs[k] + 1) + 1);
            end
        end
    endtask

    task automatic test_key_stall();
        int p, dc, bs, li, rr; logic dh, ba, es;
        run_block(2'b00, 10, 4, 3, 99, 1'b0, p, dc, bs, li, rr, dh, ba, es);
        vectors++; if (rr !== 4) begin miscompares++; $display("FAIL stall_req_cycles: got %0d want 4", rr); end
        vectors++; if (p !== 11) begin miscompares++; $display("FAIL stall_pulses: got %0d want 11", p); end
        vectors++; if (bs !== 0) begin miscompares++; $display("FAIL stall_sequence: got %0d bad want 0", bs); end
        vectors++; if (dc !== 26) begin miscompares++; $display("FAIL stall_done_cycle: got %0d want 26", dc); end
    endtask

    task automatic test_timeout();
        int req_run, err_cyc, p, dc, bs, li, rr; logic saw_done, busy_at_err, dh, ba, es;
        req_run = 0; err_cyc = -1; saw_done = 1'b0; busy_at_err = 1'b1;
        bus.key_len = 2'b00; bus.key_vld = 1'b1; bus.start = 1'b1;
        for (int c = 1; c <= 40 && err_cyc < 0; c++) begin
            tick();
            bus.start = 1'b0;
            if (bus.key_req && bus.key_idx == 4'd2) req_run++;
            if (bus.done) saw_done = 1'b1;
            if (bus.err) begin
                err_cyc = c;
                busy_at_err = bus.busy;
            end
            bus.key_vld = !(bus.key_req && bus.key_idx == 4'd2);
        end
        bus.key_vld = 1'b1;
        vectors++; if (err_cyc !== 20) begin miscompares++; $display("FAIL timeout_err_cycle: got %0d want 20", err_cyc); end
        vectors++; if (req_run !== 15) begin miscompares++; $display("FAIL timeout_req_cycles: got %0d want 15", req_run); end
        vectors++;
        if (saw_done !== 1'b0 || busy_at_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_abort: done %b busy %b want 0 0", saw_done, busy_at_err);
        end
        tick(); tick(); tick();
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", bus.err); end
        run_block(2'b00, 10, 99, 0, 99, 1'b0, p, dc, bs, li, rr, dh, ba, es);
        vectors++; if (es !== 1'b0) begin miscompares++; $display("FAIL timeout_err_cleared: got %b want 0", es); end
        vectors++; if (p !== 11 || dc !== 23) begin miscompares++; $display("FAIL timeout_rerun: pulses %0d done %0d want 11 23", p, dc); end
    endtask

    task automatic test_start_ignored();
        int p, dc, bs, li, rr; logic dh, ba, es;
        run_block(2'b00, 10, 99, 0, 5, 1'b0, p, dc, bs, li, rr, dh, ba, es);
        vectors++;
        if (p !== 11 || dc !== 23 || bs !== 0) begin
            miscompares++;
            $display("FAIL start_while_busy: pulses %0d done %0d bad %0d want 11 23 0", p, dc, bs);
        end
    endtask

    task automatic test_done_start_collision();
        int p, dc, bs, li, rr; logic dh, ba, es;
        run_block(2'b00, 10, 99, 0, 99, 1'b1, p, dc, bs, li, rr, dh, ba, es);
        vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL collision_to_idle: got %b want 0", ba); end
        tick();
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL collision_start_dropped: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        int c;
        bus.key_len = 2'b00; bus.key_vld = 1'b1; bus.start = 1'b1;
        c = 0;
        do begin
            tick(); c++;
            bus.start = 1'b0;
        end while (!(bus.round_en && bus.round_idx == 4'd3) && c < 40);
        vectors++; if (c !== 8) begin miscompares++; $display("FAIL midrun_reach_round3: cycle %0d want 8", c); end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({bus.key_req, bus.key_idx, bus.round_en, bus.round_type, bus.round_idx,
             bus.busy, bus.done, bus.err} !== 15'd0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got %b want all zero", {bus.key_req, bus.key_idx,
                     bus.round_en, bus.round_type, bus.round_idx, bus.busy, bus.done, bus.err});
        end
        tick(); rst = 1'b1; tick(); tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.round_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_stays_idle: busy %b done %b en %b want 0 0 0", bus.busy, bus.done, bus.round_en);
        end
    endtask

`ifdef AES_SEQ_ABORT_EN
    task automatic test_abort();
        int c; logic saw_done;
        bus.key_len = 2'b00; bus.key_vld = 1'b1; bus.start = 1'b1;
        c = 0; saw_done = 1'b0;
        do begin
            tick(); c++;
            bus.start = 1'b0;
        end while (!(bus.round_en && bus.round_idx == 4'd3) && c < 40);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.round_idx !== 4'd0 || bus.key_req !== 1'b0 || bus.round_en !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_to_idle: busy %b idx %0d req %b en %b want 0 0 0 0",
                     bus.busy, bus.round_idx, bus.key_req, bus.round_en);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.key_len = 2'b00; bus.key_vld = 1'b0; bus.done_ack = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_aes128();
        test_key_lengths();
        test_key_stall();
        test_timeout();
        test_start_ignored();
        test_done_start_collision();
        test_reset_mid_run();
`ifdef AES_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
